// File: rtl/apb_ecc_master.sv
// APB write initiator for the ECC_ENC_DEC slave: takes one command, issues the four
// register writes back-to-back, waits for operation_done (or timeout) and returns a response.
module apb_ecc_master #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [1:0]                 cmd_width,
    input  logic [DATA_WIDTH-1:0]      cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PENABLE,
    output logic                       PSEL,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_WIDTH-1:0]      resp_data,
    output logic [1:0]                 resp_num_errors,
    output logic                       resp_timeout,
    output logic                       busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETUP     = 3'd1;
    localparam logic [2:0] ACCESS    = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL  = AMBA_ADDR_WIDTH'(32'h00);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA  = AMBA_ADDR_WIDTH'(32'h04);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH = AMBA_ADDR_WIDTH'(32'h08);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE = AMBA_ADDR_WIDTH'(32'h0C);

    typedef struct packed {
        logic [1:0]            op;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            width;
        logic [DATA_WIDTH-1:0] noise;
    } cmd_t;

    logic [2:0]    state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    cmd_t          cmd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            cnt             <= '0;
            cmd_q           <= '0;
            resp_data       <= '0;
            resp_num_errors <= '0;
            resp_timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cmd_q <= '{op: cmd_op, data: cmd_data, width: cmd_width, noise: cmd_noise};
                    idx   <= '0;
                    state <= SETUP;
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    if (idx == 2'd3) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= SETUP;
                    end
                end
                WAIT_DONE: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    // A done in the same cycle as the timeout still wins
                    if (operation_done) begin
                        resp_data       <= data_out;
                        resp_num_errors <= num_of_errors;
                        resp_timeout    <= 1'b0;
                        state           <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LIMIT) begin
                        resp_data       <= '0;
                        resp_num_errors <= '0;
                        resp_timeout    <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // APB outputs decode straight from state so a reset drops them without waiting for an edge
    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        if (state == SETUP || state == ACCESS) begin
            PSEL    = 1'b1;
            PWRITE  = 1'b1;
            PENABLE = (state == ACCESS);
            case (idx)
                2'd0: begin PADDR = ADDR_DATA;  PWDATA[DATA_WIDTH-1:0] = cmd_q.data;  end
                2'd1: begin PADDR = ADDR_WIDTH; PWDATA[1:0]            = cmd_q.width; end
                2'd2: begin PADDR = ADDR_NOISE; PWDATA[DATA_WIDTH-1:0] = cmd_q.noise; end
                default: begin PADDR = ADDR_CTRL; PWDATA[1:0]          = cmd_q.op;    end
            endcase
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_apb_ecc_master.sv
// Directed bench for apb_ecc_master: table of commands with hand-computed APB words and
// responses, plus hand sequences for timeout, ignored early done and mid-command reset.
module tb_apb_ecc_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_width;
    logic [31:0] cmd_noise;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PENABLE, PSEL, PWRITE;
    logic        operation_done;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_num_errors;
    logic        resp_timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    apb_ecc_master #(.DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_width(cmd_width), .cmd_noise(cmd_noise),
        .PADDR(PADDR), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL), .PWRITE(PWRITE),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_num_errors(resp_num_errors), .resp_timeout(resp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [31:0]      data;
        logic [1:0]       width;
        logic [31:0]      noise;
        logic [3:0][31:0] wdata;     // expected PWDATA for DATA_IN, WIDTH, NOISE, CTRL
        int               done_wait; // WAIT_DONE cycles before done is driven
        logic [31:0]      dout;
        logic [1:0]       nerr;
        int               hold;      // cycles resp_ready is held low
    } vec_t;

    vec_t tbl[4];
    logic [19:0] exp_addr[4] = '{20'h04, 20'h08, 20'h0C, 20'h00};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [31:0] d, input logic [1:0] w,
                             input logic [31:0] n);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_width = w; cmd_noise = n;
        step();
        // scramble the command lines: the latched copy must be used
        cmd_valid = 1'b0; cmd_op = ~op; cmd_data = ~d; cmd_width = ~w; cmd_noise = ~n;
    endtask

    // Checks APB rows starting at T+1; ends in the cycle of the last checked row.
    task automatic apb_rows(input logic [3:0][31:0] wd, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            chk($sformatf("apb_ctl_r%0d", r), 64'({PSEL, PENABLE, PWRITE, busy, cmd_ready}),
                64'({1'b1, 1'(r % 2), 1'b1, 1'b1, 1'b0}));
            chk($sformatf("paddr_r%0d", r), 64'(PADDR), 64'(exp_addr[r/2]));
            chk($sformatf("pwdata_r%0d", r), 64'(PWDATA), 64'(wd[r/2]));
            if (r != nrows - 1) step();
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("idle_after_resp", 64'({cmd_ready, resp_valid, busy}), 64'({1'b1, 1'b0, 1'b0}));
    endtask

    task automatic run_vec(input vec_t v, input int id);
        start_cmd(v.op, v.data, v.width, v.noise);
        apb_rows(v.wdata, 8);
        step();  // T+9: WAIT_DONE entry
        chk($sformatf("wait_apb_v%0d", id), 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
        for (int i = 0; i < v.done_wait; i++) begin
            chk($sformatf("no_resp_v%0d_c%0d", id, i), 64'({resp_valid, busy}), 64'({1'b0, 1'b1}));
            step();
        end
        operation_done = 1'b1; data_out = v.dout; num_of_errors = v.nerr;
        step();
        operation_done = 1'b0; data_out = 32'hBAD0_BAD0; num_of_errors = 2'd3;
        chk($sformatf("resp_v%0d", id),
            64'({resp_valid, resp_timeout, resp_num_errors, resp_data, cmd_ready}),
            64'({1'b1, 1'b0, v.nerr, v.dout, 1'b0}));
        for (int h = 0; h < v.hold; h++) begin
            step();
            chk($sformatf("resp_hold_v%0d_c%0d", id, h),
                64'({resp_valid, resp_timeout, resp_num_errors, resp_data, cmd_ready}),
                64'({1'b1, 1'b0, v.nerr, v.dout, 1'b0}));
        end
        release_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        tbl[0] = '{op: 2'd0, data: 32'h0000_00A5, width: 2'd2, noise: 32'h0,
                   wdata: {32'h0, 32'h0, 32'h2, 32'hA5}, done_wait: 3,
                   dout: 32'h0000_1234, nerr: 2'd1, hold: 5};
        tbl[1] = '{op: 2'd1, data: 32'hDEAD_BEEF, width: 2'd1, noise: 32'h0001_0001,
                   wdata: {32'h1, 32'h0001_0001, 32'h1, 32'hDEAD_BEEF}, done_wait: 0,
                   dout: 32'hCAFE_F00D, nerr: 2'd2, hold: 0};
        tbl[2] = '{op: 2'd2, data: 32'h0, width: 2'd3, noise: 32'hFFFF_FFFF,
                   wdata: {32'h2, 32'hFFFF_FFFF, 32'h3, 32'h0}, done_wait: 15,
                   dout: 32'h0, nerr: 2'd3, hold: 1};
        // done lands in the very cycle the timeout would fire
        tbl[3] = '{op: 2'd0, data: 32'h8000_0001, width: 2'd0, noise: 32'h8000_0000,
                   wdata: {32'h0, 32'h8000_0000, 32'h0, 32'h8000_0001}, done_wait: 16,
                   dout: 32'h5555_AAAA, nerr: 2'd0, hold: 2};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_width = '0; cmd_noise = '0;
        operation_done = 1'b0; data_out = '0; num_of_errors = '0; resp_ready = 1'b0;
        step(); step();
        chk("reset_out", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
        chk("reset_hs", 64'({cmd_ready, busy, resp_valid, resp_timeout, resp_num_errors}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 2'd0}));
        rst = 1'b0;
        step(); step();
        chk("idle_out", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy, resp_valid}), 64'd0);
        chk("idle_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 4; i++) run_vec(tbl[i], i);

        // timeout, with a done pulse in the CTRL ACCESS cycle that must be ignored
        start_cmd(2'd2, 32'h0000_0F0F, 2'd1, 32'h0000_0003);
        apb_rows({32'h2, 32'h3, 32'h1, 32'h0F0F}, 8);
        operation_done = 1'b1; data_out = 32'hFFFF_FFFF; num_of_errors = 2'd3;
        step();
        operation_done = 1'b0;
        n = 0;
        while (!resp_valid && n < 100) begin
            step();
            n++;
        end
        chk("timeout_latency", 64'(n), 64'd17);
        chk("timeout_resp", 64'({resp_valid, resp_timeout, resp_num_errors, resp_data}),
            64'({1'b1, 1'b1, 2'd0, 32'd0}));
        release_resp();

        // reset during the NOISE SETUP cycle
        start_cmd(2'd1, 32'h1357_9BDF, 2'd2, 32'h0000_0010);
        apb_rows({32'h1, 32'h10, 32'h2, 32'h1357_9BDF}, 5);
        rst = 1'b1;
        #1;
        chk("rst_mid_apb", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
        chk("rst_mid_hs", 64'({cmd_ready, busy, resp_valid}), 64'({1'b1, 1'b0, 1'b0}));
        step();
        rst = 1'b0;
        operation_done = 1'b1;  // stray done while idle must not create a response
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            operation_done = 1'b0;
            if (resp_valid || busy || PSEL) seen++;
        end
        chk("no_resp_after_rst", 64'(seen), 64'd0);

        run_vec(tbl[1], 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_ecc_master.md
Name: apb_ecc_master

Overview:
- APB initiator that drives the ECC_ENC_DEC APB slave from a simple command port.
- Accepts one command per transaction: operation, data, codeword width and noise.
- Issues the four register writes over APB, then waits for operation_done.
- Returns data_out and num_of_errors on a response port.
- Used as the programmable front end of the stimulus path and as a reusable host-side driver.

Parameters:
- DATA_WIDTH, 32, width of data/noise words and of data_out
- AMBA_ADDR_WIDTH, 20, APB address width
- AMBA_WORD, 32, APB data bus width (>= DATA_WIDTH)
- TIMEOUT_CYCLES, 1024, max cycles waiting for operation_done; 0 disables timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clk edge
- cmd_op  in  2  CTRL value: 0 encode, 1 decode, 2 full channel
- cmd_data  in  DATA_WIDTH  DATA_IN value
- cmd_width  in  2  CODEWORD_WIDTH value
- cmd_noise  in  DATA_WIDTH  NOISE value
- PADDR  out  AMBA_ADDR_WIDTH  APB address
- PWDATA  out  AMBA_WORD  APB write data
- PENABLE  out  1  APB enable
- PSEL  out  1  APB select
- PWRITE  out  1  APB write
- operation_done  in  1  slave result-valid pulse
- data_out  in  DATA_WIDTH  slave result data
- num_of_errors  in  2  slave error count
- resp_valid  out  1  response available
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_data  out  DATA_WIDTH  captured data_out
- resp_num_errors  out  2  captured num_of_errors
- resp_timeout  out  1  response produced by timeout, not by done
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State is IDLE, counters 0, command registers 0. Reset is asynchronous and effective immediately.
- Reset mid-operation: APB signals drop at once and the in-flight command is discarded. No response is produced.
- Register map (byte offsets): CTRL 0x00, DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C.
- Write order is fixed: DATA_IN, CODEWORD_WIDTH, NOISE, CTRL. CTRL is written last because it triggers the operation.
- Narrow fields are zero-extended to AMBA_WORD.
- States:
  - IDLE: cmd_ready=1. On accept, latch all cmd_* fields, clear reg index to 0, go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA from reg index. Go to ACCESS next cycle.
  - ACCESS: PSEL=1, PENABLE=1, PADDR/PWDATA held from SETUP. There is no PREADY, so ACCESS lasts exactly 1 cycle. If index<3, increment it and go to SETUP; PSEL stays 1, with no idle cycle between writes. If index=3, go to WAIT_DONE.
  - WAIT_DONE: PSEL=PENABLE=PWRITE=0; PADDR and PWDATA return to 0. The timeout counter increments each cycle. If operation_done=1, capture data_out and num_of_errors, set resp_timeout=0 and go to RESP. Otherwise, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, set resp_data=0, resp_num_errors=0, resp_timeout=1 and go to RESP. Done takes priority over timeout in the same cycle.
  - RESP: resp_valid=1, with resp_* stable. On resp_ready, go to IDLE and clear resp_valid.
- operation_done is ignored outside WAIT_DONE, including during the CTRL ACCESS cycle.
- Latency: command accepted at edge T gives DATA_IN SETUP in T+1 and CTRL ACCESS in T+8. WAIT_DONE starts at T+9. resp_valid rises 1 cycle after the edge where done is sampled.
- cmd_* inputs may change after accept without effect. Only one command is outstanding; cmd_ready=0 from accept until return to IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates. The counter clears on entry to WAIT_DONE.

Test Plan:
- Reset then idle → all APB outputs 0, cmd_ready=1, busy=0, resp_valid=0.
- Command op=0, data=0x0000_00A5, width=2, noise=0 → four APB writes in order:
  - PADDR 0x04 / PWDATA 0xA5
  - PADDR 0x08 / 0x2
  - PADDR 0x0C / 0x0
  - PADDR 0x00 / 0x0
  
  Each write is 1 SETUP + 1 ACCESS, back-to-back, 8 cycles total. PSEL is continuous across the 8 cycles.
- After CTRL write, drive operation_done for 1 cycle with data_out=0x1234, num_of_errors=1 at T+12 → resp_valid from T+13, resp_data=0x1234, resp_num_errors=1, resp_timeout=0.
- Hold resp_ready=0 for 5 cycles → resp_* stable and cmd_ready=0. Assert resp_ready → IDLE, cmd_ready=1 the next cycle.
- TIMEOUT_CYCLES=16, never assert done → resp_valid 17 cycles after WAIT_DONE entry, resp_timeout=1, resp_data=0.
- Pulse operation_done during CTRL ACCESS → ignored, still in WAIT_DONE. Assert rst during the NOISE SETUP → PSEL=0 immediately, no response. Then a new command completes normally.
